// File: rtl/l3_pkg.sv
// Shared definitions for the shared last-level cache slice:
// FSM state encoding, counter width and a constant log2 helper.
package l3_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_RESP
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_l3_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above the
// pointer (wrapping), and moves the pointer past it on advance.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req          per-requester request lines
//   advance      commit the current grant (pointer update)
//   grant        one-hot grant, combinational from req/pointer
//   grant_idx    binary index of the granted requester
module rr_arbiter
  import l3_pkg::*;
#(
  parameter int N = 6,
  localparam int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      if (grant_idx == IW'(N - 1)) ptr <= '0;
      else ptr <= grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/shared_l3_rr.sv
// Shared direct-mapped write-through LLC slice, round-robin arbitrated.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/we/addr/wdata     packed per-core request channel
//   req_ready                   one-hot grant pulse
//   resp_valid, resp_rdata      one-hot completion pulse and read data
//   mem_req_*                   valid/ready request to memory controller
//   mem_resp_valid/rdata        read data returning from memory
//   hit_count, miss_count       saturating hit / read-miss counters
module shared_l3_rr
  import l3_pkg::*;
#(
  parameter int N_CORES = 6,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LINES   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        req_valid,
  input  logic [N_CORES-1:0]        req_we,
  input  logic [N_CORES*ADDR_W-1:0] req_addr,
  input  logic [N_CORES*DATA_W-1:0] req_wdata,
  output logic [N_CORES-1:0]        req_ready,
  output logic [N_CORES-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      mem_req_valid,
  output logic                      mem_req_we,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_wdata,
  input  logic                      mem_req_ready,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_rdata,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count
);

  localparam int IDX_W = clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int CI_W  = (N_CORES > 1) ? clog2(N_CORES) : 1;

  state_t state;
  state_t next_state;

  logic [N_CORES-1:0] arb_grant;
  logic [CI_W-1:0]    arb_idx;
  logic               take;

  logic [CI_W-1:0]    core_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DATA_W-1:0]  data_mem [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  // A grant is only committed while idle and out of reset.
  assign take = rst_n && (state == S_IDLE) && (|req_valid);

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (take),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (|req_valid) next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!we_q && hit) next_state = S_RESP;
        else next_state = S_MEM_REQ;
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          if (we_q) next_state = S_RESP;
          else next_state = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid) next_state = S_RESP;
      end
      S_RESP: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    req_ready     = '0;
    resp_valid    = '0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (rst_n) begin
      unique case (state)
        S_IDLE: begin
          req_ready = arb_grant;
        end
        S_MEM_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_we    = we_q;
          mem_req_addr  = addr_q;
          mem_req_wdata = wdata_q;
        end
        S_RESP: begin
          resp_valid = N_CORES'(1) << core_q;
          resp_rdata = rdata_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Request latch, valid bits, response data and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) begin
            core_q  <= arb_idx;
            we_q    <= req_we[arb_idx];
            addr_q  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[arb_idx*DATA_W +: DATA_W];
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            if (!we_q) rdata_q <= data_mem[idx];
          end else if (!we_q) begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready && we_q) rdata_q <= '0;
        end
        S_MEM_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[idx] <= 1'b1;
            rdata_q      <= mem_resp_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_LOOKUP) && we_q && hit) begin
      data_mem[idx] <= wdata_q;
    end
    if (rst_n && (state == S_MEM_WAIT) && mem_resp_valid) begin
      data_mem[idx] <= mem_resp_rdata;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_shared_l3_rr.sv
// Directed self-checking bench for shared_l3_rr (6 cores, 8-bit
// address/data, 16 lines) with a small hit/miss counter model.
module tb_shared_l3_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  req_valid;
  logic [5:0]  req_we;
  logic [47:0] req_addr;
  logic [47:0] req_wdata;
  logic [5:0]  req_ready;
  logic [5:0]  resp_valid;
  logic [7:0]  resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [7:0]  mem_req_addr;
  logic [7:0]  mem_req_wdata;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  shared_l3_rr dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         core;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mem_rdata;
    int         rdy_dly;
    logic       exp_mem;
    logic       exp_hit;
    logic       exp_miss;
    logic [7:0] exp_rdata;
  } txn_t;

  txn_t tbl [9];
  int   checks = 0;
  int   errors = 0;
  int   exp_h  = 0;
  int   exp_m  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input txn_t t);
    int   cyc;
    int   dly;
    logic saw;
    logic hs;
    logic got;
    @(negedge clk);
    req_valid = 6'(1) << t.core;
    req_we[t.core] = t.we;
    req_addr[t.core*8 +: 8] = t.addr;
    req_wdata[t.core*8 +: 8] = t.wdata;
    #1;
    cyc = 0;
    while (req_ready == 6'd0 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("grant", 32'(req_ready), 32'(6'(1) << t.core));
    cyc = 0;
    dly = 0;
    saw = 1'b0;
    hs  = 1'b0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid = '0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      if (resp_valid != 6'd0) begin
        got = 1'b1;
        chk("resp_core", 32'(resp_valid), 32'(6'(1) << t.core));
        chk("resp_rdata", 32'(resp_rdata), 32'(t.exp_rdata));
        if (!t.exp_mem) chk("hit_latency", 32'(cyc), 32'd2);
      end else if (mem_req_valid) begin
        saw = 1'b1;
        chk("mem_we", 32'(mem_req_we), 32'(t.we));
        chk("mem_addr", 32'(mem_req_addr), 32'(t.addr));
        if (t.we) chk("mem_wdata", 32'(mem_req_wdata), 32'(t.wdata));
        if (dly >= t.rdy_dly) begin
          mem_req_ready = 1'b1;
          hs = 1'b1;
        end else begin
          // Stray response while the request stalls must be ignored.
          mem_resp_valid = 1'b1;
          mem_resp_rdata = 8'hEE;
          dly++;
        end
      end else if (hs && !t.we) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = t.mem_rdata;
      end
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    chk("mem_used", 32'(saw), 32'(t.exp_mem));
    if (t.exp_hit) exp_h++;
    if (t.exp_miss) exp_m++;
    chk("hit_count", 32'(hit_count), 32'(exp_h));
    chk("miss_count", 32'(miss_count), 32'(exp_m));
  endtask

  initial begin
    txn_t t;
    int   cyc;
    int   gcore;

    //         core we    addr   wdata  memrd  dly mem   hit   miss  rdata
    tbl[0] = '{2, 1'b0, 8'h35, 8'h00, 8'hA7, 2, 1'b1, 1'b0, 1'b1, 8'hA7};
    tbl[1] = '{2, 1'b0, 8'h35, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'hA7};
    tbl[2] = '{1, 1'b1, 8'h35, 8'h5C, 8'h00, 1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{3, 1'b0, 8'h35, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h5C};
    tbl[4] = '{0, 1'b1, 8'h12, 8'h99, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{0, 1'b0, 8'h12, 8'h00, 8'h3C, 0, 1'b1, 1'b0, 1'b1, 8'h3C};
    tbl[6] = '{4, 1'b0, 8'h45, 8'h00, 8'h61, 0, 1'b1, 1'b0, 1'b1, 8'h61};
    tbl[7] = '{4, 1'b0, 8'h35, 8'h00, 8'h5C, 0, 1'b1, 1'b0, 1'b1, 8'h5C};
    tbl[8] = '{4, 1'b0, 8'h35, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h5C};

    rst_n = 1'b0;
    req_valid = '1;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;

    // Reset: no grant even with every core requesting.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);

    for (int i = 0; i < 2; i++) do_txn(tbl[i]);

    // Core 5 hit moves the pointer to 0 ahead of the fairness run.
    t = '{5, 1'b0, 8'h35, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'hA7};
    do_txn(t);

    @(negedge clk);
    req_valid = '1;
    req_we = '0;
    for (int c = 0; c < 6; c++) req_addr[c*8 +: 8] = 8'h35;
    #1;
    cyc = 0;
    for (int g = 0; g < 7; g++) begin
      if (g == 0) cyc = 0;
      while (req_ready == 6'd0 && cyc < 20) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      gcore = g % 6;
      chk("rr_grant", 32'(req_ready), 32'(6'(1) << gcore));
      if (g > 0) chk("rr_gap", 32'(cyc), 32'd3);
      cyc = 0;
      @(negedge clk);
      #1;
      cyc++;
      @(negedge clk);
      #1;
      cyc++;
      chk("rr_resp", 32'(resp_valid), 32'(6'(1) << gcore));
      chk("rr_rdata", 32'(resp_rdata), 32'hA7);
      exp_h++;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rr_hit_count", 32'(hit_count), 32'(exp_h));

    for (int i = 2; i < 9; i++) do_txn(tbl[i]);

    // Reset while a read miss waits on memory.
    @(negedge clk);
    req_valid = 6'b000100;
    req_we = '0;
    req_addr[2*8 +: 8] = 8'h15;
    #1;
    cyc = 0;
    while (!mem_req_valid && cyc < 20) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      cyc++;
    end
    chk("mw_mem_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("mw_rst_ready", 32'(req_ready), 32'd0);
    chk("mw_rst_mem", 32'(mem_req_valid), 32'd0);
    chk("mw_rst_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("mw_rst_hits", 32'(hit_count), 32'd0);
    chk("mw_rst_miss", 32'(miss_count), 32'd0);
    rst_n = 1'b1;
    req_valid = '0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 8'h77;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("late_resp_valid", 32'(resp_valid), 32'd0);
    chk("late_mem_valid", 32'(mem_req_valid), 32'd0);
    exp_h = 0;
    exp_m = 0;
    t = '{2, 1'b0, 8'h35, 8'h00, 8'h5C, 0, 1'b1, 1'b0, 1'b1, 8'h5C};
    do_txn(t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
